// File: rtl/res_pulse_driver.sv
// ---------------------------------------------------------------------------
// res_pulse_driver
//
// Transmit side of the res_valid/res_data result interface. Result words are
// accepted on a ready/valid push port and buffered in a small FIFO. Each word
// is then driven out as one res_valid level pulse lasting PULSE_CYCLES
// cycles. Pulses are separated by at least GAP_CYCLES+1 low cycles, so a
// receiver that samples on rising edges captures exactly one word per pulse.
//
// Optional feature (macro RES_PULSE_DRIVER_RAND_GAP_EN):
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   steps on every pop. Its low three bits stretch each gap by 0..7 cycles.
//   When undefined, there is no LFSR and every gap is exactly GAP_CYCLES.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   push_valid  producer offers push_data
//   push_data   word to transmit
//   push_ready  FIFO not full; the push is taken when valid && ready
//   res_valid   registered result pulse
//   res_data    registered result word; holds the last word sent
//   busy        FIFO non-empty or the pulse sequencer is not idle
//   sent_count  pulses started since reset; wraps at 2^32
// ---------------------------------------------------------------------------
module res_pulse_driver #(
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic [31:0]           sent_count
);

  // A gap of zero would merge adjacent pulses, so it is clamped to one.
  localparam int GAP_EFF   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int PULSE_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
`ifdef RES_PULSE_DRIVER_RAND_GAP_EN
  localparam int GAP_MAX   = GAP_EFF + 7;
`else
  localparam int GAP_MAX   = GAP_EFF;
`endif
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PCW = (PULSE_EFF > 1) ? $clog2(PULSE_EFF) : 1;
  localparam int GCW = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [1:0]            state;
  logic [PCW-1:0]        pulse_cnt;
  logic [GCW-1:0]        gap_cnt;
  logic [GCW-1:0]        gap_load;
  logic                  push;
  logic                  pop;

  // Fullness is judged on the pre-edge count, so a simultaneous pop never
  // opens room for a push on the same edge.
  assign push_ready = (count != CW'(FIFO_DEPTH));
  assign push       = push_valid && push_ready;
  assign pop        = (state == ST_IDLE) && (count != '0);
  assign busy       = (count != '0) || (state != ST_IDLE);

`ifdef RES_PULSE_DRIVER_RAND_GAP_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (pop) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Sampled when the pulse ends, i.e. after the step taken by this word's pop.
  assign gap_load = GCW'(GAP_EFF - 1) + GCW'(lfsr[2:0]);
`else
  assign gap_load = GCW'(GAP_EFF - 1);
`endif

  // NOTE: FIFO storage carries no reset; the occupancy count alone decides
  // which entries are live, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      res_valid  <= 1'b0;
      res_data   <= '0;
      sent_count <= '0;
      pulse_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            res_valid  <= 1'b1;
            res_data   <= mem[rd_ptr];
            sent_count <= sent_count + 32'd1;
            pulse_cnt  <= PCW'(PULSE_EFF - 1);
            state      <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end else begin
            res_valid <= 1'b0;
            gap_cnt   <= gap_load;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_pulse_driver.sv
// ---------------------------------------------------------------------------
// tb_res_pulse_driver
//
// Two instances: u_a with default parameters, u_b with PULSE_CYCLES=3 and
// GAP_CYCLES=2. A scheduling model predicts each instance's outputs: a
// queued word starts its pulse at the first edge where the queue held it and
// the previous word's pulse-plus-gap window has elapsed. Every negative
// clock edge compares both instances against that model; directed sequences
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_res_pulse_driver;

  localparam int DW    = 256;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          push_valid [2];
  logic [DW-1:0] push_data  [2];
  logic          push_ready [2];
  logic          res_valid  [2];
  logic [DW-1:0] res_data   [2];
  logic          busy       [2];
  logic [31:0]   sent_count [2];

  res_pulse_driver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                     .PULSE_CYCLES(1), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid[0]), .push_data(push_data[0]),
    .push_ready(push_ready[0]), .res_valid(res_valid[0]),
    .res_data(res_data[0]), .busy(busy[0]), .sent_count(sent_count[0]));

  res_pulse_driver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                     .PULSE_CYCLES(3), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid[1]), .push_data(push_data[1]),
    .push_ready(push_ready[1]), .res_valid(res_valid[1]),
    .res_data(res_data[1]), .busy(busy[1]), .sent_count(sent_count[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scheduling model ----------------
  int            m_p [2] = '{1, 3};
  int            m_g [2] = '{1, 2};
  logic [DW-1:0] m_q [2][$];
  logic [DW-1:0] m_data    [2];
  int unsigned   m_sent    [2];
  bit            m_started [2];
  longint        m_hi_end  [2];   // first cycle res_valid is low again
  longint        m_busy_end[2];   // first cycle the sequencer is idle again
  longint        m_next    [2];   // earliest edge the next pop may happen
  logic [15:0]   m_lfsr    [2];
  longint        cyc = 0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k].delete();
      m_data[k]     = '0;
      m_sent[k]     = 0;
      m_started[k]  = 1'b0;
      m_hi_end[k]   = 0;
      m_busy_end[k] = 0;
      m_next[k]     = 0;
      m_lfsr[k]     = 16'hACE1;
    end
  endfunction

  function automatic void model_edge(int k, logic pv, logic [DW-1:0] pd);
    int  occ     = m_q[k].size();
    bit  room    = (occ != DEPTH);
    int  extra   = 0;
    if (occ > 0 && cyc >= m_next[k]) begin
      m_data[k]    = m_q[k].pop_front();
      m_sent[k]    = m_sent[k] + 1;
      m_started[k] = 1'b1;
`ifdef RES_PULSE_DRIVER_RAND_GAP_EN
      m_lfsr[k] = {m_lfsr[k][14:0],
                   m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
      extra = int'(m_lfsr[k][2:0]);
`endif
      m_hi_end[k]   = cyc + m_p[k];
      m_busy_end[k] = cyc + m_p[k] + m_g[k] + extra;
      m_next[k]     = m_busy_end[k] + 1;
    end
    if (pv && room) m_q[k].push_back(pd);
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_edge(k, push_valid[k], push_data[k]);
  end

  // Compare process: outputs are stable between edges.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      string p = (k == 0) ? "a" : "b";
      check({p, ".res_valid"}, DW'(res_valid[k]),
            DW'(m_started[k] && cyc < m_hi_end[k]));
      check({p, ".res_data"}, res_data[k], m_data[k]);
      check({p, ".sent_count"}, DW'(sent_count[k]), DW'(m_sent[k]));
      check({p, ".push_ready"}, DW'(push_ready[k]), DW'(m_q[k].size() != DEPTH));
      check({p, ".busy"}, DW'(busy[k]),
            DW'(m_q[k].size() != 0 || (m_started[k] && cyc < m_busy_end[k])));
    end
  end

  // ---------------- stimulus ----------------
  // Returns just after an edge's outputs have been compared.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k, input string name);
    int n = 0;
    while (busy[k] && n < 200) begin tick(); n++; end
    check({name, "_idle_timeout"}, DW'(busy[k]), DW'(0));
  endtask

`ifdef RES_PULSE_DRIVER_RAND_GAP_EN
  task automatic run_rand(output int gaps [15]);
    int  idx = 0, npulse = 0, lowlen = 0, n = 0;
    bit  prev = 1'b0, was_ready;
    for (int i = 0; i < 15; i++) gaps[i] = 0;
    while ((idx < 16 || npulse < 16 || busy[0]) && n < 600) begin
      push_valid[0] = (idx < 16);
      push_data[0]  = DW'(idx + 32'h300);
      was_ready     = push_ready[0];
      tick();
      n++;
      if (push_valid[0] && was_ready) idx++;
      if (res_valid[0] && !prev) begin
        if (npulse > 0) gaps[npulse-1] = lowlen;
        npulse++;
        lowlen = 0;
      end else if (!res_valid[0]) lowlen++;
      prev = res_valid[0];
    end
    push_valid[0] = 1'b0;
    check("rand_pulse_count", DW'(npulse), DW'(16));
  endtask
`endif

  logic [DW-1:0] vexp [9];
  logic [DW-1:0] dexp [9];
  int            idx, n;
  bit            was_ready, saw_full, saw_pulse;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_valid[k] = 1'b0;
      push_data[k]  = '0;
    end
    repeat (2) tick();
    check("rst_res_valid", DW'(res_valid[0]), DW'(0));
    check("rst_res_data", res_data[0], DW'(0));
    check("rst_sent", DW'(sent_count[0]), DW'(0));
    check("rst_push_ready", DW'(push_ready[0]), DW'(1));
    check("rst_busy", DW'(busy[0]), DW'(0));
    rst_n = 1'b1;
    tick();

    // Single word: pulse on the edge after the push, idle three edges later.
    push_valid[0] = 1'b1; push_data[0] = DW'(32'hA5);
    tick();
    push_valid[0] = 1'b0;
    check("t1_valid_e0", DW'(res_valid[0]), DW'(0));
    check("t1_busy_e0", DW'(busy[0]), DW'(1));
    tick();
    check("t1_valid_e1", DW'(res_valid[0]), DW'(1));
    check("t1_data_e1", res_data[0], DW'(32'hA5));
    check("t1_sent_e1", DW'(sent_count[0]), DW'(1));
    tick();
    check("t1_valid_e2", DW'(res_valid[0]), DW'(0));
    check("t1_data_held", res_data[0], DW'(32'hA5));
    tick();
    check("t1_busy_e3", DW'(busy[0]), DW'(0));

    // Three back-to-back words: one pulse every three cycles.
    vexp = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    dexp = '{32'hA5, 1, 1, 1, 2, 2, 2, 3, 3};
    for (int i = 0; i < 9; i++) begin
      push_valid[0] = (i < 3);
      push_data[0]  = DW'(i + 1);
      tick();
      check($sformatf("t2_valid_%0d", i), DW'(res_valid[0]), vexp[i]);
      check($sformatf("t2_data_%0d", i), res_data[0], dexp[i]);
    end
    push_valid[0] = 1'b0;
    check("t2_sent", DW'(sent_count[0]), DW'(4));

    // Fill: 14 words offered continuously; the FIFO must fill and stall.
    wait_idle(0, "t3_pre");
    idx = 0; n = 0; saw_full = 1'b0;
    while (idx < 14 && n < 300) begin
      push_valid[0] = 1'b1;
      push_data[0]  = DW'(idx + 32'h100);
      was_ready     = push_ready[0];
      tick();
      n++;
      if (was_ready) idx++;
      if (!push_ready[0]) saw_full = 1'b1;
    end
    push_valid[0] = 1'b0;
    check("t3_push_timeout", DW'(idx), DW'(14));
    check("t3_saw_full", DW'(saw_full), DW'(1));
    wait_idle(0, "t3_drain");
    check("t3_sent", DW'(sent_count[0]), DW'(18));
    check("t3_last_data", res_data[0], DW'(32'h10D));

    // u_b: 3-cycle pulses, gap 2 -> low for 3 cycles between pulses.
    vexp = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
    dexp = '{0, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD,
             32'hBEEF, 32'hBEEF};
    for (int i = 0; i < 9; i++) begin
      push_valid[1] = (i < 2);
      push_data[1]  = (i == 0) ? DW'(32'hDEAD) : DW'(32'hBEEF);
      tick();
      check($sformatf("t4_valid_%0d", i), DW'(res_valid[1]), vexp[i]);
      check($sformatf("t4_data_%0d", i), res_data[1], dexp[i]);
    end
    push_valid[1] = 1'b0;
    wait_idle(1, "t4_drain");

    // Reset in the 2nd cycle of a pulse with 4 words still queued.
    for (int i = 0; i < 6; i++) begin
      push_valid[1] = 1'b1;
      push_data[1]  = DW'(i + 32'h200);
      tick();
    end
    push_valid[1] = 1'b0;
    n = 0;
    while (sent_count[1] != 32'd4 && n < 50) begin tick(); n++; end
    check("t5_second_pulse", DW'(sent_count[1]), DW'(4));
    check("t5_valid_before", DW'(res_valid[1]), DW'(1));
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_valid_async", DW'(res_valid[1]), DW'(0));
    check("t5_data_async", res_data[1], DW'(0));
    check("t5_sent_async", DW'(sent_count[1]), DW'(0));
    check("t5_ready_async", DW'(push_ready[1]), DW'(1));
    check("t5_busy_async", DW'(busy[1]), DW'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    saw_pulse = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (res_valid[1]) saw_pulse = 1'b1;
    end
    check("t5_no_pulse_after", DW'(saw_pulse), DW'(0));
    check("t5_sent_after", DW'(sent_count[1]), DW'(0));

`ifdef RES_PULSE_DRIVER_RAND_GAP_EN
    begin
      int g1 [15];
      int g2 [15];
      run_rand(g1);
      rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1; tick();
      run_rand(g2);
      for (int i = 0; i < 15; i++) begin
        check($sformatf("rand_gap_range_%0d", i),
              DW'(g1[i] >= 2 && g1[i] <= 9), DW'(1));
        check($sformatf("rand_gap_repeat_%0d", i), DW'(g2[i]), DW'(g1[i]));
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/res_pulse_driver.md
Name: res_pulse_driver

Overview:
- Transmit side of the res_valid/res_data result interface: accepts result words on a ready/valid push port, buffers them in an internal FIFO, and drives each one out as a single res_valid level pulse.
- Every pulse is separated by at least one low cycle, so a rising-edge-sampling receiver captures exactly one word per pulse.
- Used in testbenches and in DUT output stages as the producer feeding result-checking monitors.

Parameters:
- DATA_WIDTH, 256, width of push_data/res_data (1..256)
- FIFO_DEPTH, 8, buffer entries (power of two, >=2)
- PULSE_CYCLES, 1, cycles res_valid stays high per word (>=1)
- GAP_CYCLES, 1, minimum cycles res_valid stays low between words (>=1; 0 is illegal and is treated as 1)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- push_valid  input  1  producer offers push_data
- push_data  input  DATA_WIDTH  word to transmit
- push_ready  output  1  FIFO not full; push accepted when push_valid && push_ready at clk edge
- res_valid  output  1  result pulse, registered
- res_data  output  DATA_WIDTH  result word, registered, stable while res_valid high
- busy  output  1  FIFO non-empty or FSM not IDLE
- sent_count  output  32  number of pulses started since reset, wraps at 2^32

Behaviour:
- Reset, asynchronous with rst_n=0:
  - res_valid=0, res_data=0, sent_count=0, busy=0, push_ready=1.
  - FIFO is emptied and FSM=IDLE.
  - Reset mid-pulse drops res_valid immediately; the in-flight word and all buffered words are discarded.
- FIFO:
  - Occupancy counter 0..FIFO_DEPTH; push_ready = (count != FIFO_DEPTH).
  - Push and pop on the same edge leave count unchanged.
  - When full, push is refused even if a pop happens that edge.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, PULSE, GAP:
  - IDLE: if FIFO non-empty at an edge, pop the head, load res_data, set res_valid=1, increment sent_count, load pulse counter = PULSE_CYCLES-1, go to PULSE.
  - PULSE: while pulse counter != 0, decrement. At 0: res_valid=0, load gap counter = GAP_CYCLES-1, go to GAP.
  - GAP: while gap counter != 0, decrement. At 0, go to IDLE.
  - IDLE pops on the following edge. The low time is therefore GAP_CYCLES+1 cycles when the FIFO is non-empty, since IDLE costs one cycle.
- Latency: a word pushed at edge E into an empty FIFO with the FSM in IDLE produces res_valid high from edge E+1, held for PULSE_CYCLES cycles.
- res_data keeps the last transmitted word after res_valid falls; it is never cleared except by reset.
- busy = (count != 0) || (state != IDLE), combinational from registers.
- A push into an empty FIFO while the FSM is in GAP waits until IDLE; there is no bypass.
- Back-to-back throughput: one word per PULSE_CYCLES+GAP_CYCLES+1 cycles.

Optional Feature:
- Macro RES_PULSE_DRIVER_RAND_GAP_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances one step on every pop.
  - Gap counter load = GAP_CYCLES-1 + lfsr[2:0], so the gap is randomized from GAP_CYCLES to GAP_CYCLES+7 cycles.
  - Pulse width is unaffected.
- Undefined: no LFSR is present and the gap is exactly GAP_CYCLES.

Test Plan:
- Reset, then push 0xA5 (DATA_WIDTH=256, defaults) at edge 3 -> res_valid high for exactly cycle 4, res_data=0xA5, sent_count=1, busy=0 by cycle 7.
- Push 0x1,0x2,0x3 on consecutive edges -> three 1-cycle res_valid pulses, each followed by 2 low cycles (GAP_CYCLES+1), data in order 1,2,3, sent_count=3.
- Push 9 words with no pops possible before the 9th offer (FIFO_DEPTH=8) -> push_ready=0 after the 8th accepted word; 9th accepted only after the first pop; all 9 delivered in order.
- PULSE_CYCLES=3, GAP_CYCLES=2, push 0xDEAD -> res_valid high 3 cycles with res_data stable at 0xDEAD, then low for at least 3 cycles before the next pulse.
- Assert rst_n=0 during the 2nd cycle of a 3-cycle pulse with 4 words queued -> res_valid=0 immediately, res_data=0, sent_count=0, push_ready=1, no further pulses after release.
- With RES_PULSE_DRIVER_RAND_GAP_EN defined, push 16 words -> every low gap is within 2..9 cycles, every word is captured once in order, and the gap sequence repeats identically across two runs.
